// File: rtl/store_rmw_unit.sv
// store_rmw_unit: executes SW / SH / SB against a word-wide data memory.
// SW is a single word write; SH and SB read the word, merge the halfword or
// byte lane (little-endian) and write the word back.
//
// Build option: define MISALIGN_CHECK_EN to fault misaligned SW (addr[1:0]!=0)
// and SH (addr[0]=1). Without it, only store_type=11 faults; SW ignores
// addr[1:0] and SH ignores addr[0].
//
// Handshake: start is sampled only in IDLE (busy=0); the request fields are
// captured on that edge and may change afterwards. done pulses for exactly one
// cycle when the store has finished (err pulses with it on a faulted request),
// and the unit is back in IDLE on the following cycle, ready for a new start.
module store_rmw_unit #(
    parameter int MEM_LAT = 1   // memory read latency, 1..4 cycles
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;
    localparam logic [1:0] ST_BAD = 2'b11;

    // Index of the last WAIT cycle; the counter runs 0..LAT_LAST.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_fault;

    // Merge the store data into the read word according to the store type.
    function automatic logic [31:0] merge_word(
        input logic [1:0]  t,
        input logic [1:0]  lane,
        input logic [31:0] d,
        input logic [31:0] r
    );
        logic [31:0] w;
        w = r;
        case (t)
            ST_SH: begin
                if (lane[1]) w[31:16] = d[15:0];
                else         w[15:0]  = d[15:0];
            end
            ST_SB: begin
                case (lane)
                    2'd0:    w[7:0]   = d[7:0];
                    2'd1:    w[15:8]  = d[7:0];
                    2'd2:    w[23:16] = d[7:0];
                    default: w[31:24] = d[7:0];
                endcase
            end
            default: w = d;
        endcase
        return w;
    endfunction

    // Decide whether an incoming request must be rejected.
    always_comb begin
        req_fault = (store_type == ST_BAD);
`ifdef MISALIGN_CHECK_EN
        if (store_type == ST_SW && addr[1:0] != 2'b00) req_fault = 1'b1;
        if (store_type == ST_SH && addr[0])            req_fault = 1'b1;
`else
        req_fault = req_fault | 1'b0;
`endif
    end

    // Next-state, request capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        wait_cnt_d  = wait_cnt_q;
        mem_wdata_d = mem_wdata_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    type_d = store_type;
                    addr_d = addr;
                    data_d = data_in;
                    if (req_fault) begin
                        state_d = S_ERR;
                    end else if (store_type == ST_SW) begin
                        state_d     = S_WRITE;
                        mem_wdata_d = data_in;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d    = S_WAIT;
                wait_cnt_d = 2'd0;
            end
            S_WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    rdata_d     = mem_rdata;
                    mem_wdata_d = merge_word(type_q, addr_q[1:0], data_q, mem_rdata);
                    state_d     = S_WRITE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The memory address follows the captured address only while the
        // memory is being accessed; otherwise it holds its last value.
        if (state_d == S_READ || state_d == S_WAIT || state_d == S_WRITE) begin
            mem_addr_d = {addr_d[31:2], 2'b00};
        end

        mem_wr_d = (state_d == S_WRITE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE) || (state_d == S_ERR);
        err_d    = (state_d == S_ERR);
    end

    // State and output registers; reset clears everything, which also drops
    // a pending write immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            type_q      <= 2'b00;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            rdata_q     <= 32'd0;
            wait_cnt_q  <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed testbench for store_rmw_unit (MEM_LAT = 1).
// Cycle k is the clock period following the k-th edge after the start edge;
// outputs are sampled on the falling edge in the middle of each cycle.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] mem_rdata = 32'h0BAD_0BAD;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int base;
    logic [31:0] rd_val = 32'd0;

    store_rmw_unit #(.MEM_LAT(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .store_type (store_type),
        .addr       (addr),
        .data_in    (data_in),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, returns rd_val for any read while
    // the unit is busy; counts write strobes.
    always @(posedge clk) begin
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        mem_rdata <= (busy && !mem_wr) ? rd_val : 32'h0BAD_0BAD;
    end

    // Driver: present a request for one edge, then scramble the inputs.
    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        start      = 1'b1;
        store_type = t;
        addr       = a;
        data_in    = d;
        @(posedge clk);
        #1;
        start      = 1'b0;
        store_type = 2'($urandom_range(0, 3));
        addr       = $urandom;
        data_in    = $urandom;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b0; store_type = 2'b00; addr = 32'd0; data_in = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {mem_wr, busy, done, err});
        end
        n_cmp++;
        if (mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 00000000", mem_addr);
        end
        n_cmp++;
        if (mem_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_wdata: got %h want 00000000", mem_wdata);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sw_aligned;
        base = wr_cnt;
        issue(2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b1100) begin
            n_fail++; $display("FAIL sw_c1_flags: got %b want 1100", {mem_wr, busy, done, err});
        end
        n_cmp++;
        if (mem_addr !== 32'h0000_0010) begin
            n_fail++; $display("FAIL sw_c1_addr: got %h want 00000010", mem_addr);
        end
        n_cmp++;
        if (mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_c1_wdata: got %h want deadbeef", mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0110) begin
            n_fail++; $display("FAIL sw_c2_flags: got %b want 0110", {mem_wr, busy, done, err});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL sw_c3_idle: got %b want 0000", {mem_wr, busy, done, err});
        end
        n_cmp++;
        if (wr_cnt - base !== 1) begin
            n_fail++; $display("FAIL sw_writes: got %0d want 1", wr_cnt - base);
        end
    endtask

    task automatic test_sb_lane2;
        rd_val = 32'h1122_3344;
        issue(2'b10, 32'h0000_0022, 32'h0000_00AB);
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err, mem_addr} !== {4'b0100, 32'h0000_0020}) begin
            n_fail++; $display("FAIL sb_c1_read: got %b/%h want 0100/00000020", {mem_wr, busy, done, err}, mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0100) begin
            n_fail++; $display("FAIL sb_c2_wait: got %b want 0100", {mem_wr, busy, done, err});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr} !== {1'b1, 32'h0000_0020}) begin
            n_fail++; $display("FAIL sb_c3_addr: got %b/%h want 1/00000020", mem_wr, mem_addr);
        end
        n_cmp++;
        if (mem_wdata !== 32'h11AB_3344) begin
            n_fail++; $display("FAIL sb_c3_wdata: got %h want 11ab3344", mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0110) begin
            n_fail++; $display("FAIL sb_c4_done: got %b want 0110", {mem_wr, busy, done, err});
        end
        @(negedge clk);
    endtask

    task automatic test_sh_upper;
        rd_val = 32'hAAAA_BBBB;
        base = wr_cnt;
        issue(2'b01, 32'h0000_0102, 32'h1234_5678);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0100, 32'h5678_BBBB}) begin
            n_fail++; $display("FAIL sh_c3_write: got %b/%h/%h want 1/00000100/5678bbbb", mem_wr, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_fail++; $display("FAIL sh_c4_done: got %b want 10", {done, err});
        end
        @(negedge clk);
        n_cmp++;
        if (wr_cnt - base !== 1) begin
            n_fail++; $display("FAIL sh_writes: got %0d want 1", wr_cnt - base);
        end
    endtask

    task automatic test_misaligned;
        // Misaligned SH at byte address 3
        rd_val = 32'h1111_2222;
        base = wr_cnt;
        issue(2'b01, 32'h0000_0003, 32'h0000_CAFE);
`ifdef MISALIGN_CHECK_EN
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0111) begin
            n_fail++; $display("FAIL mis_sh_err: got %b want 0111", {mem_wr, busy, done, err});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL mis_sh_idle: got %b want 0000", {mem_wr, busy, done, err});
        end
`else
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0000, 32'hCAFE_2222}) begin
            n_fail++; $display("FAIL mis_sh_write: got %b/%h/%h want 1/00000000/cafe2222", mem_wr, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_fail++; $display("FAIL mis_sh_done: got %b want 10", {done, err});
        end
        @(negedge clk);
`endif
        // Misaligned SW at byte address 0x13
        issue(2'b00, 32'h0000_0013, 32'h0102_0304);
        @(negedge clk);
`ifdef MISALIGN_CHECK_EN
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0111) begin
            n_fail++; $display("FAIL mis_sw_err: got %b want 0111", {mem_wr, busy, done, err});
        end
        @(negedge clk);
        n_cmp++;
        if (wr_cnt - base !== 0) begin
            n_fail++; $display("FAIL mis_writes: got %0d want 0", wr_cnt - base);
        end
`else
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0010, 32'h0102_0304}) begin
            n_fail++; $display("FAIL mis_sw_write: got %b/%h/%h want 1/00000010/01020304", mem_wr, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_cnt - base !== 2) begin
            n_fail++; $display("FAIL mis_writes: got %0d want 2", wr_cnt - base);
        end
`endif
    endtask

    task automatic test_invalid;
        base = wr_cnt;
        issue(2'b11, 32'h0000_0040, 32'h5555_AAAA);
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0111) begin
            n_fail++; $display("FAIL inv_c1_err: got %b want 0111", {mem_wr, busy, done, err});
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL inv_c2_idle: got %b want 0000", {mem_wr, busy, done, err});
        end
        n_cmp++;
        if (wr_cnt - base !== 0) begin
            n_fail++; $display("FAIL inv_writes: got %0d want 0", wr_cnt - base);
        end
    endtask

    task automatic test_reset_mid;
        rd_val = 32'hCCCC_DDDD;
        base = wr_cnt;
        issue(2'b10, 32'h0000_0030, 32'h0000_0077);
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy} !== 2'b01) begin
            n_fail++; $display("FAIL rmid_wait: got %b want 01", {mem_wr, busy});
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_wr, busy, done, err, mem_addr} !== {4'b0000, 32'd0}) begin
            n_fail++; $display("FAIL rmid_clear: got %b/%h want 0000/00000000", {mem_wr, busy, done, err}, mem_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wr_cnt - base !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_nowrite: got writes=%0d busy=%b want 0/0", wr_cnt - base, busy);
        end
        issue(2'b00, 32'h0000_0050, 32'h1357_2468);
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0050, 32'h1357_2468}) begin
            n_fail++; $display("FAIL rmid_sw: got %b/%h/%h want 1/00000050/13572468", mem_wr, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        rd_val = 32'h5566_7788;
        base = wr_cnt;
        issue(2'b10, 32'h0000_0040, 32'h0000_0099);
        repeat (2) @(negedge clk);
        // start pulse during WAIT must be ignored
        start = 1'b1; store_type = 2'b00; addr = 32'h0000_0060; data_in = 32'hFFFF_0000;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0040, 32'h5566_7799}) begin
            n_fail++; $display("FAIL b2b_c3_write: got %b/%h/%h want 1/00000040/55667799", mem_wr, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0110) begin
            n_fail++; $display("FAIL b2b_c4_done: got %b want 0110", {mem_wr, busy, done, err});
        end
        // Hold start across the DONE edge and the following IDLE edge
        start = 1'b1; store_type = 2'b00; addr = 32'h0000_0080; data_in = 32'h0BAD_F00D;
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_c5_idle: got %b want 0000", {mem_wr, busy, done, err});
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_0080, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL b2b_c6_sw: got %b/%h/%h want 1/00000080/0badf00d", mem_wr, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_c7_done: got %b want 10", {done, err});
        end
        n_cmp++;
        if (wr_cnt - base !== 2) begin
            n_fail++; $display("FAIL b2b_writes: got %0d want 2", wr_cnt - base);
        end
    endtask

    // Sequence the scenarios and report
    initial begin
        test_reset;
        test_sw_aligned;
        test_sb_lane2;
        test_sh_upper;
        test_misaligned;
        test_invalid;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the register write-back data selection: moves register data into memory instead of memory data into the register file.
- Executes SW, SH and SB against the word-wide data memory.
- SW is a single write; SH and SB run a read-modify-write sequence: read the word, merge the byte or halfword lane, write the word back.
- Sits between the datapath (B register / ALUOut) and the memory port, and is sequenced by the control unit through a start/done handshake.

Parameters:
- MEM_LAT, 1: memory read latency in cycles, counted from the cycle the read address is driven to the cycle mem_rdata is valid. Legal range is 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  store request; sampled only in IDLE.
- store_type  in  2  00 = SW, 01 = SH, 10 = SB, 11 = invalid.
- addr  in  32  byte address of the store.
- data_in  in  32  register data; SH uses [15:0], SB uses [7:0].
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  word address {addr_q[31:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_wr  out  1  memory write enable; 0 means read.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for a misaligned or invalid store.

Behaviour:
- Reset: asynchronous, active-low. While reset_n is low, the FSM goes to IDLE and every output and internal register reads 0.
- Reset mid-operation: mem_wr drops immediately with reset, and no partial write completes after reset deasserts.
- Start acceptance:
  - In IDLE with start=1, store_type, addr and data_in are latched into _q registers on the clock edge.
  - start is ignored while busy=1.
  - Inputs may change after the accepting edge without effect.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- Transitions:
  - IDLE -> ERR if the request is invalid or misaligned (see Optional Feature).
  - IDLE -> WRITE for SW.
  - IDLE -> READ for SH or SB.
  - READ -> WAIT.
  - WAIT stays for MEM_LAT cycles; mem_rdata is captured into rdata_q on the last WAIT edge; then WAIT -> WRITE.
  - WRITE -> DONE.
  - DONE -> IDLE.
  - ERR -> IDLE.
- Outputs by state:
  - mem_addr is driven from addr_q in READ, WAIT and WRITE, and holds its last value otherwise.
  - mem_wr = 1 only in WRITE, for exactly one cycle.
  - done = 1 in DONE and in ERR.
  - err = 1 in ERR only.
  - ERR never asserts mem_wr.
- Merge rules (little-endian lanes, byte k = bits 8k+7:8k):
  - SW: mem_wdata = data_q.
  - SH: lane = addr_q[1]. The halfword data_q[15:0] replaces rdata_q[16*lane+15:16*lane]; the other half is unchanged.
  - SB: lane = addr_q[1:0]. data_q[7:0] replaces byte lane; the other three bytes are unchanged.
- Latency, with the start edge at cycle 0:
  - SW: WRITE in cycle 1, done in cycle 2.
  - SH/SB: READ in cycle 1, WAIT in cycles 2..1+MEM_LAT, WRITE in cycle 2+MEM_LAT, done in cycle 3+MEM_LAT. With MEM_LAT=1, done is in cycle 4.
  - Error: done and err together in cycle 1.
- Back-to-back stores: start may be high in the cycle after DONE (the FSM is then in IDLE), and is accepted there. There is no dead cycle beyond DONE.
- store_type=11 always goes to ERR, regardless of the macro.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - SW with addr[1:0] != 00 goes to ERR.
  - SH with addr[0] = 1 goes to ERR.
  - SB never faults.
- MISALIGN_CHECK_EN undefined:
  - No alignment fault; err fires only for store_type=11.
  - SW ignores addr[1:0].
  - SH ignores addr[0] and uses lane addr[1].

Test Plan:
- SW aligned: addr=0x0000_0010, data_in=0xDEAD_BEEF -> cycle 1 mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2 done=1, err=0.
- SB lane 2: mem_rdata=0x1122_3344, addr=0x0000_0022, data_in=0x0000_00AB, MEM_LAT=1 -> cycle 3 mem_wr=1, mem_addr=0x20, mem_wdata=0x11AB_3344; cycle 4 done=1.
- SH upper half: mem_rdata=0xAAAA_BBBB, addr=0x0000_0102, data_in=0x1234_5678 -> mem_wdata=0x5678_BBBB; one write only.
- Misaligned SH: addr=0x0000_0003.
  - With MISALIGN_CHECK_EN: done=1 and err=1 in cycle 1, mem_wr never asserts.
  - Without: lane 1 is written normally.
- Reset mid-operation: assert reset_n=0 during WAIT of an SB -> busy=0 and mem_wr=0 immediately. After release, no write occurs and a new SW is accepted normally.
- Start while busy plus back-to-back: pulse start during an SB's WAIT -> ignored, only one write. Hold start in the cycle after DONE -> second SW accepted and its write seen in the next cycle.
